hazard_mc: RTL

- Parametrised hazard unit for the 5-stage MIPS pipeline: data forwarding select, load-use and branch stalls, and stall/flush control.
- Manages NUM_MC multi-cycle execute units, e.g. divider and multiplier. Each unit runs in handshake mode (waits for done) or fixed-latency mode (internal countdown).
- A per-channel FSM stalls the instruction in E for exactly the unit's duration and never re-issues a start for the same instruction.
- Supports pipeline-wide abort (exception flush) mid-operation.

---
 rtl/hazard_mc.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hazard_mc.sv
// Hazard unit for a 5-stage MIPS pipeline.
// Covers operand forwarding, load-use and branch stalls, and per-channel
// control of multi-cycle execute units (fixed-latency or done-handshake),
// with a pipeline-wide abort that cancels any unit still busy.
module hazard_mc #(
    parameter int unsigned               REG_AW   = 5,
    parameter int unsigned               NUM_MC   = 2,
    parameter int unsigned               CNT_W    = 6,
    parameter logic [NUM_MC-1:0]         MC_FIXED = 2'b10,
    parameter logic [NUM_MC*CNT_W-1:0]   MC_LAT   = {6'd32, 6'd0}
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic [NUM_MC-1:0] mc_reqE,
    input  logic [NUM_MC-1:0] mc_done,
    input  logic              flush_all,
    output logic [NUM_MC-1:0] mc_start,
    output logic [NUM_MC-1:0] mc_cancel,
    output logic [NUM_MC-1:0] mc_busy,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              forwardaD,
    output logic              forwardbD
);

    // DONE lasts one cycle: it is the cycle in which E is released, and the
    // still-asserted request belongs to the finished instruction.
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mc_state_e;

    mc_state_e        state_q [NUM_MC];
    mc_state_e        state_d [NUM_MC];
    logic [CNT_W-1:0] cnt_q   [NUM_MC];
    logic [CNT_W-1:0] cnt_d   [NUM_MC];

    logic [NUM_MC-1:0] start_c;
    logic [NUM_MC-1:0] cancel_c;
    logic [NUM_MC-1:0] busy_c;
    logic [NUM_MC-1:0] stall_c;
    logic              lwstall;
    logic              branchstall;
    logic              mc_stall;

    // Load-use and branch-operand hazards seen from D.
    always_comb begin
        lwstall = memtoregE && regwriteE && (writeregE != '0) &&
                  ((rsD == writeregE) || (rtD == writeregE));
        branchstall = branchD &&
            ((regwriteE && (writeregE != '0) &&
              ((writeregE == rsD) || (writeregE == rtD))) ||
             (memtoregM && (writeregM != '0) &&
              ((writeregM == rsD) || (writeregM == rtD))));
    end

    // Per-channel next state, counter, start/cancel pulses and stall request.
    always_comb begin
        for (int i = 0; i < NUM_MC; i++) begin
            // NOTE: every signal driven here gets a default first so no path
            // leaves it unassigned, which would otherwise infer a latch.
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            start_c[i]  = 1'b0;
            cancel_c[i] = 1'b0;
            busy_c[i]   = (state_q[i] == S_BUSY);
            stall_c[i]  = ((state_q[i] == S_IDLE) && mc_reqE[i]) ||
                          (state_q[i] == S_BUSY);
            if (flush_all) begin
                state_d[i]  = S_IDLE;
                cnt_d[i]    = '0;
                cancel_c[i] = (state_q[i] == S_BUSY);
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        if (mc_reqE[i]) begin
                            start_c[i] = 1'b1;
                            cnt_d[i]   = MC_LAT[i*CNT_W +: CNT_W] - CNT_W'(1);
                            state_d[i] = S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (MC_FIXED[i]) begin
                            if (cnt_q[i] == '0) state_d[i] = S_DONE;
                            else                cnt_d[i]   = cnt_q[i] - CNT_W'(1);
                        end else if (mc_done[i]) begin
                            state_d[i] = S_DONE;
                        end
                    end
                    S_DONE:  state_d[i] = S_IDLE;
                    default: state_d[i] = S_IDLE;
                endcase
            end
        end
        mc_stall = |stall_c;
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the per-channel registers are a handful of flops, not a
            // RAM, so clearing them in reset costs nothing and keeps the
            // counters well-defined.
            for (int i = 0; i < NUM_MC; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            for (int i = 0; i < NUM_MC; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Output decode: forwarding, stalls and flushes; abort wins, reset zeros all.
    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        forwardaD = 1'b0;
        forwardbD = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        mc_start  = '0;
        mc_cancel = '0;
        mc_busy   = '0;
        if (resetn) begin
            if ((rsE != '0) && regwriteM && (rsE == writeregM))      forwardaE = 2'b10;
            else if ((rsE != '0) && regwriteW && (rsE == writeregW)) forwardaE = 2'b01;
            if ((rtE != '0) && regwriteM && (rtE == writeregM))      forwardbE = 2'b10;
            else if ((rtE != '0) && regwriteW && (rtE == writeregW)) forwardbE = 2'b01;
            forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
            forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
            mc_busy   = busy_c;
            if (flush_all) begin
                flushD    = 1'b1;
                flushE    = 1'b1;
                flushM    = 1'b1;
                mc_cancel = cancel_c;
            end else begin
                stallE   = mc_stall;
                stallF   = lwstall || branchstall || mc_stall;
                stallD   = lwstall || branchstall || mc_stall;
                // A bubble over a held E would destroy the multi-cycle op.
                flushE   = (lwstall || branchstall) && !mc_stall;
                mc_start = start_c;
            end
        end
    end

endmodule
